line_track_sequencer: RTL and testbench

//  Steering sequencer for the two-motor line-tracking car. Samples a 3-bit IR line sensor, filters it,
//  and selects FWD / TURN / SEARCH / HALT. Drives per-motor mode and duty to the motor/PWM block:

---
 rtl/line_track_pkg.sv | 27 ++
 rtl/motor_dir_guard.sv | 99 +++++++++
 rtl/line_track_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_line_track_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/line_track_pkg.sv
// ----------------------------------------------------------------------------
// line_track_pkg
// Shared encodings for the line-tracking car sequencer:
//   - motor mode codes driven to the motor/PWM block
//   - FSM state encoding (also visible on the state_o debug port)
//   - last-turn memory values used to pick the SEARCH pivot direction
// No ports (package).
// ----------------------------------------------------------------------------
package line_track_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_STOP = 2'd0;
   localparam mode_t MODE_FWD  = 2'd1;
   localparam mode_t MODE_BWD  = 2'd2;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FWD    = 3'd1;
   localparam logic [2:0] ST_TURN_L = 3'd2;
   localparam logic [2:0] ST_TURN_R = 3'd3;
   localparam logic [2:0] ST_SEARCH = 3'd4;
   localparam logic [2:0] ST_HALT   = 3'd5;

   localparam logic TURN_LEFT  = 1'b0;
   localparam logic TURN_RIGHT = 1'b1;

endpackage

// File: rtl/motor_dir_guard.sv
// ----------------------------------------------------------------------------
// motor_dir_guard
// Per-motor output stage: registers the requested mode, inserts a stop
// dead-time on every direction reversal and ramps the duty from DUTY_START
// up to DUTY_MAX in DUTY_STEP increments per control tick.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   tick_i  in   one-cycle control tick
//   des_i   in   desired mode from the sequencer FSM
//   mode_o  out  registered motor mode
//   duty_o  out  10-bit duty, 0 whenever mode_o is stop
// ----------------------------------------------------------------------------
module motor_dir_guard
   import line_track_pkg::*;
#(
   parameter int unsigned DEADTIME   = 20,
   parameter logic [9:0]  DUTY_START = 10'd400,
   parameter logic [9:0]  DUTY_STEP  = 10'd10,
   parameter logic [9:0]  DUTY_MAX   = 10'd690
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_i,
   input  mode_t      des_i,
   output mode_t      mode_o,
   output logic [9:0] duty_o
);

   localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;

   mode_t         mode_q,   mode_d;
   logic [9:0]    duty_q,   duty_d;
   logic          dt_on_q,  dt_on_d;
   logic [DW-1:0] dt_cnt_q, dt_cnt_d;

   // Sum is formed one bit wider so a large step can never wrap past the cap.
   function automatic logic [9:0] duty_ramp(input logic [9:0] d);
      logic [10:0] sum;
      sum = {1'b0, d} + {1'b0, DUTY_STEP};
      return (sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : sum[9:0];
   endfunction

   always_comb begin
      mode_d   = mode_q;
      duty_d   = duty_q;
      dt_on_d  = dt_on_q;
      dt_cnt_d = dt_cnt_q;
      if (dt_on_q) begin
         // Output is already stopped; a stop request simply cancels the wait,
         // any other request is taken only when the timer expires.
         if (des_i == MODE_STOP) begin
            dt_on_d = 1'b0;
         end else if (tick_i) begin
            if (dt_cnt_q == DW'(DEADTIME - 1)) begin
               dt_on_d = 1'b0;
               mode_d  = des_i;
               duty_d  = DUTY_START;
            end else begin
               dt_cnt_d = dt_cnt_q + 1'b1;
            end
         end
      end else if (des_i != mode_q) begin
         if (mode_q == MODE_STOP) begin
            mode_d = des_i;
            duty_d = DUTY_START;
         end else if (des_i == MODE_STOP) begin
            mode_d = MODE_STOP;
            duty_d = '0;
         end else begin
            // Reversal: stop now, restart after the dead-time.
            mode_d   = MODE_STOP;
            duty_d   = '0;
            dt_on_d  = 1'b1;
            dt_cnt_d = '0;
         end
      end else if (mode_q != MODE_STOP && tick_i) begin
         duty_d = duty_ramp(duty_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q   <= MODE_STOP;
         duty_q   <= '0;
         dt_on_q  <= 1'b0;
         dt_cnt_q <= '0;
      end else begin
         mode_q   <= mode_d;
         duty_q   <= duty_d;
         dt_on_q  <= dt_on_d;
         dt_cnt_q <= dt_cnt_d;
      end
   end

   assign mode_o = mode_q;
   assign duty_o = duty_q;

endmodule

// File: rtl/line_track_sequencer.sv
// ----------------------------------------------------------------------------
// line_track_sequencer
// Steering sequencer for the two-motor line-tracking car. Divides clk into a
// control tick, synchronises and debounces the 3-bit IR sensor, runs the
// IDLE/FWD/TURN_L/TURN_R/SEARCH/HALT FSM and drives both motor guards.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   enable   in   run request (level)
//   sensor   in   {left,centre,right} IR sensor, asynchronous
//   l_mode   out  left motor mode   (0 stop, 1 forward, 2 backward)
//   r_mode   out  right motor mode
//   l_duty   out  left motor duty   (1024 = 100 %)
//   r_duty   out  right motor duty
//   state_o  out  current FSM state (debug)
//   lost     out  SEARCH timed out; cleared when enable drops
// ----------------------------------------------------------------------------
module line_track_sequencer
   import line_track_pkg::*;
#(
   parameter int unsigned TICK_DIV     = 100_000,
   parameter int unsigned FILT_LEN     = 4,
   parameter int unsigned DEADTIME     = 20,
   parameter int unsigned LOST_TIMEOUT = 500,
   parameter logic [9:0]  DUTY_START   = 10'd400,
   parameter logic [9:0]  DUTY_STEP    = 10'd10,
   parameter logic [9:0]  DUTY_MAX     = 10'd690
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [2:0] sensor,
   output logic [1:0] l_mode,
   output logic [1:0] r_mode,
   output logic [9:0] l_duty,
   output logic [9:0] r_duty,
   output logic [2:0] state_o,
   output logic       lost
);

   localparam int TW = (TICK_DIV > 1)     ? $clog2(TICK_DIV)     : 1;
   localparam int FW = $clog2(FILT_LEN + 1);
   localparam int LW = (LOST_TIMEOUT > 1) ? $clog2(LOST_TIMEOUT) : 1;

   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic          tick;
   logic [2:0]    sync1_q, sync2_q;
   logic [2:0]    cand_q, cand_d, filt_q, filt_d;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [2:0]    state_q, state_d, sel;
   logic          last_turn_q, last_turn_d;
   logic          lost_q, lost_d;
   logic [LW-1:0] lost_cnt_q, lost_cnt_d;
   mode_t         l_des, r_des;

   assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
   assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

   // Debounce: the count saturates at FILT_LEN, so re-loading filt with the
   // same candidate on later ticks is harmless.
   always_comb begin
      cand_d = cand_q;
      fcnt_d = fcnt_q;
      filt_d = filt_q;
      if (tick) begin
         if (sync2_q == cand_q) begin
            if (fcnt_q != FW'(FILT_LEN)) fcnt_d = fcnt_q + 1'b1;
         end else begin
            cand_d = sync2_q;
            fcnt_d = FW'(1);
         end
         if (fcnt_d == FW'(FILT_LEN)) filt_d = cand_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      lost_d      = lost_q;
      last_turn_d = last_turn_q;
      lost_cnt_d  = lost_cnt_q;
      case (filt_q)
         3'b010, 3'b111: sel = ST_FWD;
         3'b100, 3'b110: sel = ST_TURN_L;
         3'b001, 3'b011: sel = ST_TURN_R;
         3'b000:         sel = ST_SEARCH;
         default:        sel = state_q;     // 101: ambiguous, keep steering
      endcase
      if (!enable) begin
         state_d = ST_IDLE;
         lost_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE:                      state_d = ST_FWD;
            ST_FWD, ST_TURN_L, ST_TURN_R: state_d = sel;
            ST_SEARCH: begin
               if (sel == ST_SEARCH && tick && lost_cnt_q == LW'(LOST_TIMEOUT - 1)) begin
                  state_d = ST_HALT;
                  lost_d  = 1'b1;
               end else begin
                  state_d = sel;
               end
            end
            ST_HALT:                      state_d = ST_HALT;
            default:                      state_d = ST_IDLE;
         endcase
      end
      if (state_d == ST_TURN_L) last_turn_d = TURN_LEFT;
      if (state_d == ST_TURN_R) last_turn_d = TURN_RIGHT;
      if (state_d == ST_SEARCH && state_q != ST_SEARCH) begin
         lost_cnt_d = '0;
      end else if (state_q == ST_SEARCH && tick) begin
         lost_cnt_d = lost_cnt_q + 1'b1;
      end
   end

   always_comb begin
      l_des = MODE_STOP;
      r_des = MODE_STOP;
      case (state_q)
         ST_FWD:    begin l_des = MODE_FWD;  r_des = MODE_FWD;  end
         ST_TURN_L: begin l_des = MODE_STOP; r_des = MODE_FWD;  end
         ST_TURN_R: begin l_des = MODE_FWD;  r_des = MODE_STOP; end
         ST_SEARCH: begin
            // Pivot in place toward the side the line was last seen on.
            if (last_turn_q == TURN_LEFT) begin
               l_des = MODE_BWD; r_des = MODE_FWD;
            end else begin
               l_des = MODE_FWD; r_des = MODE_BWD;
            end
         end
         default:   begin l_des = MODE_STOP; r_des = MODE_STOP; end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt_q  <= '0;
         sync1_q     <= '0;
         sync2_q     <= '0;
         cand_q      <= '0;
         fcnt_q      <= '0;
         filt_q      <= '0;
         state_q     <= ST_IDLE;
         last_turn_q <= TURN_LEFT;
         lost_q      <= 1'b0;
         lost_cnt_q  <= '0;
      end else begin
         tick_cnt_q  <= tick_cnt_d;
         sync1_q     <= sensor;
         sync2_q     <= sync1_q;
         cand_q      <= cand_d;
         fcnt_q      <= fcnt_d;
         filt_q      <= filt_d;
         state_q     <= state_d;
         last_turn_q <= last_turn_d;
         lost_q      <= lost_d;
         lost_cnt_q  <= lost_cnt_d;
      end
   end

   motor_dir_guard #(
      .DEADTIME   (DEADTIME),
      .DUTY_START (DUTY_START),
      .DUTY_STEP  (DUTY_STEP),
      .DUTY_MAX   (DUTY_MAX)
   ) u_left (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_i (tick),
      .des_i  (l_des),
      .mode_o (l_mode),
      .duty_o (l_duty)
   );

   motor_dir_guard #(
      .DEADTIME   (DEADTIME),
      .DUTY_START (DUTY_START),
      .DUTY_STEP  (DUTY_STEP),
      .DUTY_MAX   (DUTY_MAX)
   ) u_right (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick_i (tick),
      .des_i  (r_des),
      .mode_o (r_mode),
      .duty_o (r_duty)
   );

   assign state_o = state_q;
   assign lost    = lost_q;

endmodule

// File: tb/tb_line_track_sequencer.sv
// ----------------------------------------------------------------------------
// tb_line_track_sequencer
// Directed, table-driven bench. Small parameters: TICK_DIV=4, FILT_LEN=2,
// DEADTIME=3, LOST_TIMEOUT=10, DUTY_STEP=100. After reset release the control
// ticks land on clock edges 4, 8, 12, ...; edge numbers in the comments count
// from the release.
// ----------------------------------------------------------------------------
module tb_line_track_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [2:0] sensor;
   logic [1:0] l_mode, r_mode;
   logic [9:0] l_duty, r_duty;
   logic [2:0] state_o;
   logic       lost;

   int n_tests = 0;
   int n_fail  = 0;

   line_track_sequencer #(
      .TICK_DIV     (4),
      .FILT_LEN     (2),
      .DEADTIME     (3),
      .LOST_TIMEOUT (10),
      .DUTY_START   (10'd400),
      .DUTY_STEP    (10'd100),
      .DUTY_MAX     (10'd690)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .sensor  (sensor),
      .l_mode  (l_mode),
      .r_mode  (r_mode),
      .l_duty  (l_duty),
      .r_duty  (r_duty),
      .state_o (state_o),
      .lost    (lost)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic [2:0] sen;
      int         clks;
      logic [2:0] st;
      logic [1:0] lm;
      logic [1:0] rm;
      logic [9:0] ld;
      logic [9:0] rd;
      logic       lost;
   } vec_t;

   vec_t t1[$];
   vec_t tm[$];

   function automatic vec_t mk(input logic en, input logic [2:0] sen, input int clks,
                               input logic [2:0] st, input logic [1:0] lm, input logic [1:0] rm,
                               input logic [9:0] ld, input logic [9:0] rd, input logic ls);
      vec_t x;
      x.en = en; x.sen = sen; x.clks = clks; x.st = st;
      x.lm = lm; x.rm = rm; x.ld = ld; x.rd = rd; x.lost = ls;
      return x;
   endfunction

   task automatic check(input string name, input logic [2:0] st, input logic [1:0] lm,
                        input logic [1:0] rm, input logic [9:0] ld, input logic [9:0] rd,
                        input logic ls);
      n_tests++;
      if ({state_o, l_mode, r_mode, l_duty, r_duty, lost} !== {st, lm, rm, ld, rd, ls}) begin
         n_fail++;
         $display("FAIL %s: got st=%0d L=%0d/%0d R=%0d/%0d lost=%0d, expected st=%0d L=%0d/%0d R=%0d/%0d lost=%0d",
                  name, state_o, l_mode, l_duty, r_mode, r_duty, lost, st, lm, ld, rm, rd, ls);
      end
   endtask

   // Called 1 ns after a clock edge: drive inputs, advance, sample 1 ns after the last edge.
   task automatic run_vec(input vec_t x, input string name);
      enable = x.en;
      sensor = x.sen;
      repeat (x.clks) @(posedge clk);
      #1;
      check(name, x.st, x.lm, x.rm, x.ld, x.rd, x.lost);
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      enable = 1'b0;
      sensor = 3'b010;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      // Test 1: filter settles on 010 with enable low, then run straight ahead.
      //            en    sen     clk st  L  R  Lduty   Rduty   lost
      t1.push_back(mk(1'b0, 3'b010, 8, 0, 0, 0, 10'd0,   10'd0,   1'b0)); // E8  filtered=010
      t1.push_back(mk(1'b1, 3'b010, 1, 1, 0, 0, 10'd0,   10'd0,   1'b0)); // E9  IDLE->FWD
      t1.push_back(mk(1'b1, 3'b010, 1, 1, 1, 1, 10'd400, 10'd400, 1'b0)); // E10 modes follow
      t1.push_back(mk(1'b1, 3'b010, 1, 1, 1, 1, 10'd400, 10'd400, 1'b0)); // E11
      t1.push_back(mk(1'b1, 3'b010, 1, 1, 1, 1, 10'd500, 10'd500, 1'b0)); // E12 tick
      t1.push_back(mk(1'b1, 3'b010, 4, 1, 1, 1, 10'd600, 10'd600, 1'b0)); // E16
      t1.push_back(mk(1'b1, 3'b010, 4, 1, 1, 1, 10'd690, 10'd690, 1'b0)); // E20 capped
      t1.push_back(mk(1'b1, 3'b010, 4, 1, 1, 1, 10'd690, 10'd690, 1'b0)); // E24 holds

      // Test 2: FWD -> TURN_L.
      tm.push_back(mk(1'b1, 3'b100, 8, 1, 1, 1, 10'd690, 10'd690, 1'b0)); // E32 filtered=100
      tm.push_back(mk(1'b1, 3'b100, 1, 2, 1, 1, 10'd690, 10'd690, 1'b0)); // E33 TURN_L
      tm.push_back(mk(1'b1, 3'b100, 1, 2, 0, 1, 10'd0,   10'd690, 1'b0)); // E34 left stops
      // Test 3a: TURN_L -> SEARCH {2,1}, left 0->2 without dead-time.
      tm.push_back(mk(1'b1, 3'b000, 10, 2, 0, 1, 10'd0,  10'd690, 1'b0)); // E44
      tm.push_back(mk(1'b1, 3'b000, 1, 4, 0, 1, 10'd0,   10'd690, 1'b0)); // E45 SEARCH
      tm.push_back(mk(1'b1, 3'b000, 1, 4, 2, 1, 10'd400, 10'd690, 1'b0)); // E46
      tm.push_back(mk(1'b1, 3'b000, 2, 4, 2, 1, 10'd500, 10'd690, 1'b0)); // E48
      tm.push_back(mk(1'b1, 3'b000, 8, 4, 2, 1, 10'd690, 10'd690, 1'b0)); // E56
      // Test 4: SEARCH timeout -> HALT, sensor ignored, enable low -> IDLE.
      tm.push_back(mk(1'b1, 3'b000, 27, 4, 2, 1, 10'd690, 10'd690, 1'b0)); // E83 9 ticks seen
      tm.push_back(mk(1'b1, 3'b000, 1, 5, 2, 1, 10'd690, 10'd690, 1'b1)); // E84 10th tick
      tm.push_back(mk(1'b1, 3'b000, 1, 5, 0, 0, 10'd0,   10'd0,   1'b1)); // E85
      tm.push_back(mk(1'b1, 3'b010, 12, 5, 0, 0, 10'd0,  10'd0,   1'b1)); // E97 still HALT
      tm.push_back(mk(1'b0, 3'b010, 1, 0, 0, 0, 10'd0,   10'd0,   1'b0)); // E98 IDLE
      // Test 3b: TURN_R {1,0} -> SEARCH {1,2}, right 0->2 immediate.
      tm.push_back(mk(1'b0, 3'b001, 10, 0, 0, 0, 10'd0,  10'd0,   1'b0)); // E108 filtered=001
      tm.push_back(mk(1'b1, 3'b001, 1, 1, 0, 0, 10'd0,   10'd0,   1'b0)); // E109 FWD
      tm.push_back(mk(1'b1, 3'b001, 1, 3, 1, 1, 10'd400, 10'd400, 1'b0)); // E110 TURN_R
      tm.push_back(mk(1'b1, 3'b001, 1, 3, 1, 0, 10'd400, 10'd0,   1'b0)); // E111
      tm.push_back(mk(1'b1, 3'b001, 1, 3, 1, 0, 10'd500, 10'd0,   1'b0)); // E112 tick
      tm.push_back(mk(1'b1, 3'b000, 9, 4, 1, 0, 10'd690, 10'd0,   1'b0)); // E121 SEARCH
      tm.push_back(mk(1'b1, 3'b000, 1, 4, 1, 2, 10'd690, 10'd400, 1'b0)); // E122
      // Test 3c: SEARCH {1,2} -> TURN_L {0,1}, right reversal held 3 ticks.
      tm.push_back(mk(1'b1, 3'b100, 11, 2, 1, 2, 10'd690, 10'd690, 1'b0)); // E133 TURN_L
      tm.push_back(mk(1'b1, 3'b100, 1, 2, 0, 0, 10'd0,   10'd0,   1'b0)); // E134 dead-time
      tm.push_back(mk(1'b1, 3'b100, 9, 2, 0, 0, 10'd0,   10'd0,   1'b0)); // E143 two ticks in
      tm.push_back(mk(1'b1, 3'b100, 1, 2, 0, 1, 10'd0,   10'd400, 1'b0)); // E144 third tick
      tm.push_back(mk(1'b1, 3'b100, 4, 2, 0, 1, 10'd0,   10'd500, 1'b0)); // E148
      // Test 5: back to FWD, then a one-tick 001 glitch.
      tm.push_back(mk(1'b1, 3'b010, 9, 1, 0, 1, 10'd0,   10'd690, 1'b0)); // E157 FWD
      tm.push_back(mk(1'b1, 3'b010, 1, 1, 1, 1, 10'd400, 10'd690, 1'b0)); // E158
      tm.push_back(mk(1'b1, 3'b001, 4, 1, 1, 1, 10'd500, 10'd690, 1'b0)); // E162 glitch held
      tm.push_back(mk(1'b1, 3'b010, 4, 1, 1, 1, 10'd600, 10'd690, 1'b0)); // E166
      tm.push_back(mk(1'b1, 3'b010, 9, 1, 1, 1, 10'd690, 10'd690, 1'b0)); // E175 unchanged
      // Test 6 setup: FWD -> SEARCH {2,1}, left reversal enters dead-time.
      tm.push_back(mk(1'b1, 3'b000, 10, 4, 1, 1, 10'd690, 10'd690, 1'b0)); // E185 SEARCH
      tm.push_back(mk(1'b1, 3'b000, 1, 4, 0, 1, 10'd0,   10'd690, 1'b0)); // E186 dead-time

      do_reset();
      check("reset", 3'd0, 2'd0, 2'd0, 10'd0, 10'd0, 1'b0);
      for (int i = 0; i < t1.size(); i++) run_vec(t1[i], $sformatf("t1[%0d]", i));
      for (int i = 0; i < tm.size(); i++) run_vec(tm[i], $sformatf("tm[%0d]", i));

      // Test 6: asynchronous reset mid dead-time with the right motor running.
      #2 rst_n = 1'b0;
      #1 check("async_reset", 3'd0, 2'd0, 2'd0, 10'd0, 10'd0, 1'b0);
      do_reset();
      check("reset2", 3'd0, 2'd0, 2'd0, 10'd0, 10'd0, 1'b0);
      for (int i = 0; i < t1.size(); i++) run_vec(t1[i], $sformatf("t1_again[%0d]", i));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
